// File: rtl/gmii_rx_mac.sv
// gmii_rx_mac: GMII receive MAC. Strips preamble/SFD and FCS, checks CRC-32,
// length and PHY errors, and writes bytes plus a status trailer to a 9-bit FIFO.
module gmii_rx_mac #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic       phy_rx_clk,
  input  logic       sys_rst_n,
  input  logic       phy_rx_dv,
  input  logic       phy_rx_er,
  input  logic [7:0] phy_rxd,
  input  logic       fifo_full,
  output logic       wr_en,
  output logic [8:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int unsigned LEN_W       = 13;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [7:0]  STAT_GOOD   = 8'h01;

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_PRE,
    S_DATA
  } state_e;

  state_e           state_q;
  logic             dv_q;
  logic             er_q;
  logic [7:0]       rxd_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [3:0][7:0]  dly_q;
  logic             er_seen_q;
  logic             ovf_q;
  logic             pend_q;
  logic [7:0]       pend_stat_q;
  logic [7:0]       stat_d;
  logic             data_wr_d;
  logic             sfd_d;

  // Reflected CRC-32 byte update, LSB first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  // Input stage r1: register the PHY pins once.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      rxd_q <= 8'h00;
    end else begin
      dv_q  <= phy_rx_dv;
      er_q  <= phy_rx_er;
      rxd_q <= phy_rxd;
    end
  end

  // Per-byte datapath helpers: CRC step, saturating length, write gating, status.
  always_comb begin
    crc_d     = crc_upd(crc_q, rxd_q);
    len_d     = (&len_q) ? len_q : len_q + LEN_W'(1);
    data_wr_d = (len_q >= LEN_W'(4)) && (len_q < LEN_W'(MAX_LEN)) && !ovf_q;
    stat_d    = {3'b000,
                 len_q > LEN_W'(MAX_LEN),
                 len_q < LEN_W'(MIN_LEN),
                 ovf_q,
                 er_seen_q,
                 crc_q == CRC_RESIDUE};
    sfd_d     = dv_q && (rxd_q == SFD_BYTE) && !((state_q == S_PRE) && er_q);
  end

  // Receive FSM with registered FIFO write port and status pulses.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_WAIT;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      dly_q       <= '0;
      er_seen_q   <= 1'b0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_stat_q <= 8'h00;
      wr_en       <= 1'b0;
      wr_data     <= 9'h000;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // A deferred trailer goes out on the first cycle the FIFO has room.
      if (pend_q && !fifo_full) begin
        wr_en     <= 1'b1;
        wr_data   <= {1'b0, pend_stat_q};
        frame_ok  <= (pend_stat_q == STAT_GOOD);
        frame_err <= (pend_stat_q != STAT_GOOD);
        pend_q    <= 1'b0;
      end

      case (state_q)
        S_WAIT: begin
          if (!dv_q) state_q <= S_IDLE;
        end

        S_IDLE, S_PRE: begin
          if (!dv_q) begin
            state_q <= S_IDLE;
          end else if (sfd_d) begin
            // A frame arriving behind an undelivered trailer is dropped whole.
            if (pend_q) begin
              state_q <= S_WAIT;
            end else begin
              state_q   <= S_DATA;
              crc_q     <= CRC_INIT;
              len_q     <= '0;
              er_seen_q <= 1'b0;
              ovf_q     <= 1'b0;
            end
          end else if ((rxd_q == PRE_BYTE) && !((state_q == S_PRE) && er_q)) begin
            state_q <= S_PRE;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_DATA: begin
          if (dv_q) begin
            crc_q     <= crc_d;
            len_q     <= len_d;
            er_seen_q <= er_seen_q | er_q;
            dly_q     <= {dly_q[2:0], rxd_q};
            // Byte leaving the 4-deep line is payload; the FCS never leaves it.
            if (data_wr_d) begin
              if (fifo_full) begin
                ovf_q <= 1'b1;
              end else begin
                wr_en   <= 1'b1;
                wr_data <= {1'b1, dly_q[3]};
              end
            end
          end else begin
            state_q <= S_IDLE;
            if (!fifo_full) begin
              wr_en     <= 1'b1;
              wr_data   <= {1'b0, stat_d};
              frame_ok  <= (stat_d == STAT_GOOD);
              frame_err <= (stat_d != STAT_GOOD);
            end else begin
              pend_q      <= 1'b1;
              pend_stat_q <= stat_d;
            end
          end
        end

        default: state_q <= S_WAIT;
      endcase
    end
  end

endmodule
